bitwise_logic_unit: RTL
=======================

# bitwise_logic_unit

Parametrised, pipelined bitwise logic unit: the next generation of the single-gate AND block in the execute stage. It takes two WIDTH-bit operands and a 3-bit opcode and runs one of eight logic or accumulate operations. The result passes through a configurable number of register stages, with a valid flag, pipeline stall and pipeline flush. A persistent accumulator register supports AND/OR reduction across consecutive operations.

## Interface
- WIDTH, 32: operand, result and accumulator width (1..64).
- STAGES, 2: number of result register stages (1..4); equals the latency.
- clk  in  1  single clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- in_valid  in  1  operand/opcode present this cycle.
- op  in  3  opcode (encodings under Operation).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- stall  in  1  freeze the pipeline and the accumulator.
- flush  in  1  kill all in-flight results.
- out_valid  out  1  result valid.
- result  out  WIDTH  result of the oldest in-flight operation.
- acc  out  WIDTH  current accumulator value (registered).
- acc_zero  out  1  acc == 0 (combinational from the acc register).

## Operation
- Opcodes (applied to a and b):
  - 000 AND: a & b.
  - 001 OR: a | b.
  - 010 XOR: a ^ b.
  - 011 NOR: ~(a | b).
  - 100 ANDN: a & ~b.
  - 101 ACC_AND: acc_next = acc & a.
  - 110 ACC_OR: acc_next = acc | a.
  - 111 ACC_LOAD: acc_next = a.
- For opcodes 101/110/111, b is ignored and the result is acc_next (the post-update value).
- Accept condition: in_valid & ~stall & ~flush. Only an accepted operation enters stage 1 or changes acc.
- Accumulator:
  - Updates only on an accepted 101/110/111.
  - Back-to-back accumulate operations chain without bubbles; each operation sees the acc written by the one before it.
- Stall:
  - Every stage register, every valid bit and acc hold their values.
  - out_valid and result stay stable.
  - in_valid is ignored, and the upstream holds its operands.
- Flush:
  - Clears all stage valid bits on the next edge. A same-cycle input is dropped.
  - acc is not affected.
  - Flush overrides stall.
- Stage data registers load only when their incoming valid is set. Dead slots keep stale data; result is don't-care while out_valid = 0.
- All arithmetic is bitwise at WIDTH; there is no carry or overflow.

## Timing
- Reset values:
  - out_valid = 0.
  - result = 0, and all stage data registers = 0.
  - All valid bits = 0.
  - acc = all-ones, so acc_zero = 0.
- Reset overrides stall, flush and in_valid.
- Reset asserted mid-operation discards every in-flight result. out_valid is 0 in the first cycle after the reset edge.
- Latency:
  - An operation accepted at edge k appears with out_valid = 1 after edge k+STAGES-1, and stays visible until edge k+STAGES.
  - With STAGES = 1, the result is visible in the cycle directly after acceptance.
- Each stall cycle adds one cycle of latency to every in-flight operation.
- Throughput: one operation per cycle when there is no stall.
- acc shows its new value one cycle after the accepting edge.
- Simultaneous events, in priority order: reset > flush > stall > accept.

## Structure
- Package bitwise_logic_pkg holds:
  - the 3-bit opcode localparams (OP_AND .. OP_ACC_LOAD);
  - the WIDTH and STAGES range limits.
- Sub-module logic_pipe_stage:
  - one valid+data register with stall/flush/reset behaviour;
  - instantiated STAGES times in a generate loop.
- The opcode decode and the accumulator stay in the top module.

## Test plan
- Reset, then STAGES = 2, WIDTH = 32: accept AND of a = 0xF0F0_1234 and b = 0x0FF0_FFFF. out_valid = 1 two cycles later with result 0x00F0_1234. All earlier outputs are 0, and acc = 0xFFFF_FFFF.
- All eight opcodes back-to-back with a = 0xA5A5_A5A5, b = 0x0F0F_0F0F:
  - results in order 0x0505_0505, 0xAFAF_AFAF, 0xAAAA_AAAA, 0x5050_5050, 0xA0A0_A0A0;
  - then acc values 0xA5A5_A5A5 (ACC_AND), 0xA5A5_A5A5 (ACC_OR), 0xA5A5_A5A5 (ACC_LOAD);
  - one result per cycle, with no gaps.
- Accumulate chain:
  - ACC_LOAD 0x0000_00FF, then ACC_AND 0x0000_000F, then ACC_AND 0x0000_00F0, on consecutive cycles.
  - Results 0xFF, 0x0F, 0x00.
  - acc_zero rises one cycle after the third accept.
- Stall 3 cycles while two operations are in flight: out_valid and result are frozen, acc is unchanged, and each result arrives 3 cycles late with the correct value.
- Flush with stall high and in_valid high, while two operations are in flight: no out_valid pulse follows; acc keeps its pre-flush value; the next accepted operation completes normally.
- Reset asserted with stall = 1 and a full pipeline: after the edge, out_valid = 0, result = 0 and acc = 0xFFFF_FFFF.

Source files
------------

// File: rtl/bitwise_logic_pkg.sv
// Shared opcode encodings and parameter limits for the bitwise logic unit.
// Imported by the top module and by the pipeline stage.
package bitwise_logic_pkg;

    localparam logic [2:0] OP_AND      = 3'b000;
    localparam logic [2:0] OP_OR       = 3'b001;
    localparam logic [2:0] OP_XOR      = 3'b010;
    localparam logic [2:0] OP_NOR      = 3'b011;
    localparam logic [2:0] OP_ANDN     = 3'b100;
    localparam logic [2:0] OP_ACC_AND  = 3'b101;
    localparam logic [2:0] OP_ACC_OR   = 3'b110;
    localparam logic [2:0] OP_ACC_LOAD = 3'b111;

    localparam int WIDTH_MIN  = 1;
    localparam int WIDTH_MAX  = 64;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 4;

    // Opcodes 101/110/111 read and write the accumulator; b is ignored for them.
    function automatic logic is_acc_op(input logic [2:0] opcode);
        return opcode[2] & (opcode[1] | opcode[0]);
    endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid+data pipeline register. Flush beats stall; data only loads
// when the incoming slot is valid, so dead slots keep stale data.
module logic_pipe_stage
    import bitwise_logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/bitwise_logic_unit.sv
// Pipelined bitwise logic unit with a persistent AND/OR accumulator.
// Opcode decode and accumulator live here; the result ripples through STAGES registers.
module bitwise_logic_unit
    import bitwise_logic_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] acc,
    output logic             acc_zero
);

    logic             accept;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] op_result;

    logic             stage_valid [STAGES+1];
    logic [WIDTH-1:0] stage_data  [STAGES+1];

    assign accept = in_valid & ~stall & ~flush;

    // Accumulate opcodes return the post-update value so chained ops see each other.
    always_comb begin
        acc_next  = acc_q;
        op_result = '0;
        case (op)
            OP_AND:      op_result = a & b;
            OP_OR:       op_result = a | b;
            OP_XOR:      op_result = a ^ b;
            OP_NOR:      op_result = ~(a | b);
            OP_ANDN:     op_result = a & ~b;
            OP_ACC_AND: begin
                acc_next  = acc_q & a;
                op_result = acc_next;
            end
            OP_ACC_OR: begin
                acc_next  = acc_q | a;
                op_result = acc_next;
            end
            OP_ACC_LOAD: begin
                acc_next  = a;
                op_result = acc_next;
            end
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        if (accept && is_acc_op(op)) begin
            acc_d = acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '1;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign stage_valid[0] = accept;
    assign stage_data[0]  = op_result;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .stall  (stall),
            .flush  (flush),
            .valid_i(stage_valid[s]),
            .data_i (stage_data[s]),
            .valid_o(stage_valid[s+1]),
            .data_o (stage_data[s+1])
        );
    end

    assign out_valid = stage_valid[STAGES];
    assign result    = stage_data[STAGES];
    assign acc       = acc_q;
    assign acc_zero  = (acc_q == '0);

endmodule
